result_frame_writer: RTL
========================

# result_frame_writer

Collects the filtered pixel stream produced by the 3x3 window pipeline, which runs downstream of the frame reader, and stores it into an on-chip result frame buffer. Once the frame is complete, it streams the buffer back out in raster order. It is the write-side counterpart of the input frame memory: the window reader turns a stored 100x100 frame into pixel triplets, and this block turns the 98x98 result stream back into a stored frame and drains it for dump or display.

## Interface
- OUT_W, 98, result frame width in pixels (input width 100 minus 2)
- OUT_H, 98, result frame height in pixels
- DATA_W, 8, pixel width in bits
- ADDR_W, 14, buffer address width; must satisfy 2^ADDR_W >= OUT_W*OUT_H
- clock  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high
- in_valid  input  1  in_data holds a result pixel
- in_data  input  DATA_W  result pixel, raster order
- in_ready  output  1  block accepts a pixel this cycle
- drain_start  input  1  one-cycle request to begin streaming the stored frame
- out_valid  output  1  out_data holds a stored pixel
- out_data  output  DATA_W  stored pixel, raster order
- out_ready  input  1  consumer accepts out_data
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is written
- row  output  8  row index of the next write, 0..OUT_H-1
- col  output  8  column index of the next write, 0..OUT_W-1

## Operation
- The buffer is DATA_W x (OUT_W*OUT_H) and has a synchronous read port. The address is a linear counter; no multiply.
- States: FILL, FULL, PREFETCH, DRAIN.
- FILL:
  - in_ready=1.
  - When in_valid && in_ready, write in_data at wr_addr, then increment wr_addr and col.
  - When col==OUT_W-1, col wraps to 0 and row increments.
  - On the write to wr_addr==OUT_W*OUT_H-1: go to FULL, pulse frame_done, and clear wr_addr/row/col to 0.
- FULL:
  - in_ready=0.
  - Wait for drain_start, then go to PREFETCH. drain_start in any other state is ignored.
- PREFETCH:
  - Issue a read of rd_addr=0.
  - Next cycle go to DRAIN, with out_valid=1.
- DRAIN:
  - out_data is held stable while out_valid && !out_ready.
  - When out_valid && out_ready: if rd_addr==N-1, drop out_valid, clear rd_addr, and go to FILL. Otherwise increment rd_addr and fetch the next pixel so it is presented the following cycle without a bubble. A one-entry holding register handles the read latency.
- Buffer contents persist across frames; each frame overwrites every location.
- Width rules: row and col are 8-bit. N=OUT_W*OUT_H is computed in a package constant, not at runtime.

## Timing
- Reset values: state=FILL, in_ready=1, out_valid=0, out_data=0, frame_done=0, row=0, col=0, wr_addr=0, rd_addr=0.
- in_ready is combinational from state only, with no dependence on in_valid.
- frame_done is asserted the cycle after the final write is accepted, for exactly one cycle.
- Drain latency: drain_start at cycle t gives out_valid=1 with pixel 0 at t+2.
- With out_ready held at 1, one pixel is delivered per cycle, so N consecutive cycles.
- in_ready rises again the cycle after the last drain transfer.
- in_valid while in_ready=0 is dropped. The upstream stage must hold its data until in_ready is high.
- A reset asserted mid-FILL or mid-DRAIN aborts immediately. The partial frame is discarded logically (counters cleared); buffer contents are undefined.
- drain_start coinciding with the final write is ignored, because the block is not yet in FULL.

## Structure
- Shared package `frame_pkg` holds OUT_W, OUT_H, DATA_W, N_PIX=OUT_W*OUT_H, ADDR_W, and the state enum. The window reader takes its frame dimensions from the same package.
- One sub-module: `result_ram`, a single-clock simple-dual-port RAM (1 write port, 1 synchronous read port) inferred as block RAM.
- The top level holds the FSM, the write counters, the read counter, and the output holding register.

## Test plan
- Reset then fill: stream N pixels with in_data = addr mod 256 and in_valid held at 1 → frame_done pulses once, the cycle after pixel 9603; row/col pass (0,97)→(1,0); in_ready=0 afterwards.
- Drain with out_ready=1 throughout: drain_start → out_valid at +2, out_data sequence 0,1,…,255,0,… for 9604 cycles, then out_valid=0 and in_ready=1.
- Drain with out_ready toggled 1010…: no pixel lost or duplicated; out_data stable while stalled; 9604 transfers total.
- Input gaps: in_valid random at 50% → exactly 9604 writes; frame_done pulses once; drained data matches the written data.
- Ignored requests: drain_start during FILL and during DRAIN → no effect; in_valid during FULL → data not written, and the next frame's pixel 0 is still written at addr 0.
- Reset mid-operation: reset at pixel 5000 of FILL, then at pixel 3000 of DRAIN → all outputs return to their reset values the next cycle; a subsequent full frame fills and drains correctly.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared frame geometry and writer state encoding for the window pipeline blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package frame_pkg;

    localparam int OUT_W  = 98;
    localparam int OUT_H  = 98;
    localparam int DATA_W = 8;
    localparam int N_PIX  = OUT_W * OUT_H;
    localparam int ADDR_W = 14;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
    localparam logic [7:0]        LAST_COL  = 8'(OUT_W - 1);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        FULL     = 2'd1,
        PREFETCH = 2'd2,
        DRAIN    = 2'd3
    } state_t;

endpackage

// File: rtl/result_ram.sv
// Simple dual-port result frame buffer: one write port, one registered read port.
// Latency: read data valid one cycle after rd_en; rd_dat holds when rd_en is low.
// Backpressure: none; the caller gates rd_en to stall the output.
module result_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 9604
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/result_frame_writer.sv
// Stores the 98x98 filtered stream into a frame buffer, then drains it in raster order.
// Latency: frame_done one cycle after the last write; first pixel two cycles after drain_start.
// Backpressure: in_ready low outside FILL; out_data held while out_valid && !out_ready.
module result_frame_writer
    import frame_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              drain_start,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              frame_done,
    output logic [7:0]        row,
    output logic [7:0]        col
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_rd_dat;
    logic              wr_fire;
    logic              rd_fire;

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = rd_addr + 1'b1;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && (wr_addr == LAST_ADDR)) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (drain_start) begin
                    state_nxt = PREFETCH;
                end
            end
            PREFETCH: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = '0;
                state_nxt   = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // Fetch the successor now so it is presented next cycle with no bubble.
                    if (rd_addr == LAST_ADDR) begin
                        state_nxt = FILL;
                    end else begin
                        ram_rd_en = 1'b1;
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;

    // The RAM read register only updates on rd_en, so it doubles as the output holding stage.
    assign out_data = (state == DRAIN) ? ram_rd_dat : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FILL;
            wr_addr    <= '0;
            rd_addr    <= '0;
            row        <= '0;
            col        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            if (wr_fire) begin
                if (wr_addr == LAST_ADDR) begin
                    wr_addr    <= '0;
                    row        <= '0;
                    col        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + 8'd1;
                    end else begin
                        col <= col + 8'd1;
                    end
                end
            end
            if (rd_fire) begin
                rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
            end
        end
    end

    result_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (N_PIX)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr),
        .wr_dat  (in_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_dat  (ram_rd_dat)
    );

endmodule
